// File: rtl/fsm_xy_monitor.sv
// fsm_xy_monitor: observer for the {x,y} output code of the two-in/two-out
// FSM stage. It keeps saturating statistics on the sampled code stream and
// flags each completion of the Gray walk 00 -> 01 -> 11 -> 10.
//
// Ports:
//   clk      in   posedge clock
//   rst      in   asynchronous active-high reset
//   en       in   sample enable
//   x, y     in   observed code bits, code = {x,y}
//   clr      in   synchronous clear of statistics and detector state
//   rd_en    in   single-cycle read request
//   rd_sel   in   [2:0] read select: 0..3 cnt0..cnt3, 4 max_run,
//                 5 trans, 6 hits, 7 zero
//   rd_data  out  [CNT_W-1:0] registered read data, held while idle
//   rd_valid out  one-cycle pulse qualifying rd_data
//   seq_hit  out  one-cycle pulse after the edge that sampled the final 10
module fsm_xy_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             y,
    input  logic             clr,
    input  logic             rd_en,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             seq_hit
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_S00,
        ST_S01,
        ST_S11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    logic [CNT_W-1:0] r_cnt2;
    logic [CNT_W-1:0] r_cnt3;
    logic [CNT_W-1:0] r_trans;
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_hits;
    logic [1:0]       r_prev_code;
    logic             r_prev_valid;
    logic             r_seq_hit;
    logic [CNT_W-1:0] r_rd_data;
    logic             r_rd_valid;

    // ---------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------
    state_t           w_state_nxt;
    logic             w_hit;
    logic [1:0]       w_code;
    logic             w_sample;
    logic             w_same;
    logic             w_changed;
    logic [CNT_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] w_rd_mux;

    assign w_code   = {x, y};
    // clr has priority: a sample in a clearing cycle is discarded.
    assign w_sample = en & ~clr;

    // Comparisons against the previous code only mean something once a
    // sample has been taken since reset/clear.
    assign w_same    = r_prev_valid & (w_code == r_prev_code);
    assign w_changed = r_prev_valid & (w_code != r_prev_code);
    assign w_run_nxt = w_same ? sat_inc(r_run) : CNT_ONE;

    // ---------------------------------------------------------------
    // Walk detector: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Walk detector: next state / hit decode
    // A 00 from any state restarts the walk, which lets an aborted
    // walk overlap with a fresh one.
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        if (clr) begin
            w_state_nxt = ST_IDLE;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_code == 2'b00) w_state_nxt = ST_S00;
                    else                 w_state_nxt = ST_IDLE;
                end
                ST_S00: begin
                    if (w_code == 2'b00)      w_state_nxt = ST_S00;
                    else if (w_code == 2'b01) w_state_nxt = ST_S01;
                    else                      w_state_nxt = ST_IDLE;
                end
                ST_S01: begin
                    if (w_code == 2'b00)      w_state_nxt = ST_S00;
                    else if (w_code == 2'b11) w_state_nxt = ST_S11;
                    else                      w_state_nxt = ST_IDLE;
                end
                ST_S11: begin
                    if (w_code == 2'b00) begin
                        w_state_nxt = ST_S00;
                    end else if (w_code == 2'b10) begin
                        w_state_nxt = ST_IDLE;
                        w_hit       = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Per-code occurrence counters
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= CNT_ZERO;
            r_cnt1 <= CNT_ZERO;
            r_cnt2 <= CNT_ZERO;
            r_cnt3 <= CNT_ZERO;
        end else if (clr) begin
            r_cnt0 <= CNT_ZERO;
            r_cnt1 <= CNT_ZERO;
            r_cnt2 <= CNT_ZERO;
            r_cnt3 <= CNT_ZERO;
        end else if (w_sample) begin
            case (w_code)
                2'b00:   r_cnt0 <= sat_inc(r_cnt0);
                2'b01:   r_cnt1 <= sat_inc(r_cnt1);
                2'b10:   r_cnt2 <= sat_inc(r_cnt2);
                default: r_cnt3 <= sat_inc(r_cnt3);
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Transitions, run length and previous-code tracking
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trans      <= CNT_ZERO;
            r_run        <= CNT_ZERO;
            r_max        <= CNT_ZERO;
            r_prev_code  <= 2'b00;
            r_prev_valid <= 1'b0;
        end else if (clr) begin
            r_trans      <= CNT_ZERO;
            r_run        <= CNT_ZERO;
            r_max        <= CNT_ZERO;
            r_prev_code  <= 2'b00;
            r_prev_valid <= 1'b0;
        end else if (w_sample) begin
            if (w_changed) begin
                r_trans <= sat_inc(r_trans);
            end
            r_run <= w_run_nxt;
            // max_run tracks the freshly updated run in the same edge.
            if (w_run_nxt > r_max) begin
                r_max <= w_run_nxt;
            end
            r_prev_code  <= w_code;
            r_prev_valid <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Hit counter and hit pulse
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hits    <= CNT_ZERO;
            r_seq_hit <= 1'b0;
        end else if (clr) begin
            r_hits    <= CNT_ZERO;
            r_seq_hit <= 1'b0;
        end else begin
            r_seq_hit <= w_sample & w_hit;
            if (w_sample && w_hit) begin
                r_hits <= sat_inc(r_hits);
            end
        end
    end

    // ---------------------------------------------------------------
    // Read port: the mux sees register outputs, so a read returns the
    // value from before any update (including a clear) on that edge.
    // ---------------------------------------------------------------
    always_comb begin
        w_rd_mux = CNT_ZERO;
        case (rd_sel)
            3'd0:    w_rd_mux = r_cnt0;
            3'd1:    w_rd_mux = r_cnt1;
            3'd2:    w_rd_mux = r_cnt2;
            3'd3:    w_rd_mux = r_cnt3;
            3'd4:    w_rd_mux = r_max;
            3'd5:    w_rd_mux = r_trans;
            3'd6:    w_rd_mux = r_hits;
            default: w_rd_mux = CNT_ZERO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= CNT_ZERO;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign seq_hit  = r_seq_hit;

endmodule

// File: tb/tb_fsm_xy_monitor.sv
// Bench for fsm_xy_monitor: directed walks plus random traffic, checked
// against a model that derives every statistic from the sample history.
module tb_fsm_xy_monitor;

    localparam int CNT_W = 8;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             x = 1'b0;
    logic             y = 1'b0;
    logic             clr = 1'b0;
    logic             rd_en = 1'b0;
    logic [2:0]       rd_sel = 3'd0;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;
    logic             seq_hit;

    int errors = 0;
    int checks = 0;
    int hits_seen = 0;

    int hist[$];   // codes sampled since the last reset/clear
    int rdq[$];    // expected read data, one per issued read
    bit hq[$];     // expected seq_hit, one per stimulus cycle

    fsm_xy_monitor #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .clr(clr),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data),
        .rd_valid(rd_valid), .seq_hit(seq_hit)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic bit walk_at(int i);
        return i >= 3 && hist[i-3] == 0 && hist[i-2] == 1 &&
               hist[i-1] == 3 && hist[i] == 2;
    endfunction

    // Statistic as defined on the sample history.
    function automatic int stat(int sel);
        int n = 0;
        int run = 0;
        int best = 0;
        case (sel)
            0, 1, 2, 3: begin
                foreach (hist[i]) if (hist[i] == sel) n++;
            end
            4: begin
                foreach (hist[i]) begin
                    if (i > 0 && hist[i] == hist[i-1]) run++;
                    else run = 1;
                    if (run > best) best = run;
                end
                n = best;
            end
            5: begin
                foreach (hist[i]) if (i > 0 && hist[i] != hist[i-1]) n++;
            end
            6: begin
                foreach (hist[i]) if (walk_at(i)) n++;
            end
            default: n = 0;
        endcase
        return sat(n);
    endfunction

    task automatic step(bit e, bit [1:0] c, bit cl, bit re, bit [2:0] sel);
        int rexp;
        bit hit;
        hit = 1'b0;
        en = e; x = c[1]; y = c[0]; clr = cl;
        rd_en = re; rd_sel = sel;
        rexp = stat(int'(sel));
        if (cl) begin
            hist.delete();
        end else if (e) begin
            hist.push_back(int'(c));
            hit = walk_at(hist.size() - 1);
        end
        @(posedge clk);
        if (re) rdq.push_back(rexp);
        hq.push_back(hit);
        #1;
        en = 1'b0; clr = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic read(bit [2:0] sel);
        step(1'b0, 2'b00, 1'b0, 1'b1, sel);
    endtask

    task automatic read_all();
        for (int s = 0; s < 8; s++) read(3'(s));
    endtask

    // Monitor: outputs sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (seq_hit) hits_seen++;
            if (hq.size() > 0) check("seq_hit", int'(seq_hit), int'(hq.pop_front()));
            if (rdq.size() > 0) begin
                check("rd_valid", int'(rd_valid), 1);
                if (rd_valid) check("rd_data", int'(rd_data), rdq[0]);
                void'(rdq.pop_front());
            end else begin
                check("rd_valid_idle", int'(rd_valid), 0);
            end
        end
    end

    initial begin
        int h0;
        int last;
        bit [1:0] c;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_seq_hit", int'(seq_hit), 0);
        check("rst_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        read_all();

        // Plain walk
        h0 = hits_seen;
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        idle();
        check("walk_hits", hits_seen - h0, 1);
        read_all();

        // Restart via 00
        step(1, 2'b00, 1, 0, 0);
        h0 = hits_seen;
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        idle();
        check("restart_hits", hits_seen - h0, 1);
        read_all();

        // Saturation: 300 samples of 11, read after the last one
        step(1, 2'b00, 1, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 2'b11, 0, 0, 0);
        read(3'd3);
        read(3'd4);
        read(3'd5);
        step(1, 2'b11, 0, 1, 3'd3);
        read(3'd3);

        // en toggling mid-walk
        step(1, 2'b00, 1, 0, 0);
        h0 = hits_seen;
        step(1, 2'b00, 0, 0, 0);
        step(0, 2'b11, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        idle();
        check("en_gap_hits", hits_seen - h0, 1);
        read(3'd3);

        // clr colliding with the completing sample and a read
        h0 = hits_seen;
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0);
        step(1, 2'b10, 1, 1, 3'd6);
        idle();
        check("clr_hits", hits_seen - h0, 0);
        read(3'd6);
        step(1, 2'b01, 0, 0, 0);
        read(3'd5);
        read(3'd1);

        // Async reset in S11 with a read result showing
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b11, 0, 1, 3'd0);
        rst = 1'b1;
        #1;
        check("arst_rd_valid", int'(rd_valid), 0);
        check("arst_rd_data", int'(rd_data), 0);
        check("arst_seq_hit", int'(seq_hit), 0);
        hq.delete();
        rdq.delete();
        hist.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        h0 = hits_seen;
        step(1, 2'b10, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        idle();
        check("post_rst_hits", hits_seen - h0, 1);
        read_all();

        // Random traffic, biased towards the walk
        last = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                case (last)
                    0: c = 2'b01;
                    1: c = 2'b11;
                    3: c = 2'b10;
                    default: c = 2'b00;
                endcase
            end else begin
                c = 2'($urandom_range(3, 0));
            end
            step($urandom_range(3, 0) != 0, c,
                 $urandom_range(63, 0) == 0,
                 $urandom_range(1, 0) == 1,
                 3'($urandom_range(7, 0)));
            if (en == 1'b0) last = int'(c);
        end
        read_all();

        idle();
        idle();
        check("reads_drained", rdq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_xy_monitor.md
Name: fsm_xy_monitor

Overview:
- Downstream observer for the two-input/two-output FSM stage (i,j in; x,y out).
- Samples the stage's {x,y} output code each enabled cycle and keeps statistics: per-code occurrence counts, code transitions, longest run, and hits of the Gray walk 00→01→11→10.
- Statistics are read through a one-cycle-latency register read port.
- Used by benches and on-chip debug to check FSM output behaviour without probing internal state.

Parameters:
- CNT_W, 8: width of all statistic counters; all counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample enable; {x,y} is sampled only when en=1.
- x  input  1  FSM output bit x (MSB of code).
- y  input  1  FSM output bit y (LSB of code).
- clr  input  1  synchronous clear of all statistics and detector state.
- rd_en  input  1  read request, single-cycle.
- rd_sel  input  3  read select.
- rd_data  output  CNT_W  read data.
- rd_valid  output  1  one-cycle pulse; rd_data is valid while it is high.
- seq_hit  output  1  one-cycle pulse when the walk 00,01,11,10 completes.

Behaviour:
- Code: code = {x,y}. A "sample" is any posedge with en=1, rst=0 and clr=0.
- Reset (rst high, asynchronous): all counters 0, prev_valid=0, FSM in IDLE, rd_data=0, rd_valid=0, seq_hit=0. Reset asserted mid-read drops the pending rd_valid.
- Per-code counters cnt0..cnt3: +1 on each sample of that code; saturate, no wrap.
- Transition counter trans: +1 on a sample whose code differs from the previous sample's code.
  - Requires prev_valid=1. The first sample after reset/clr never counts; it only sets prev_valid=1.
  - Saturates.
- Run length cur_run (internal):
  - First sample after reset/clr sets cur_run=1.
  - Each later sample: cur_run+1 if the code equals the previous code, else 1. Saturates.
  - max_run = max(max_run, new cur_run), updated in the same cycle.
- Sequence FSM (evaluated on samples only; holds when en=0; overlap allowed):
  - IDLE: 00→S00; any other code→IDLE.
  - S00: 00→S00; 01→S01; else→IDLE.
  - S01: 00→S00; 11→S11; else→IDLE.
  - S11: 00→S00; 10→IDLE and hit; else→IDLE.
  - On a hit, seq_hit=1 on the cycle after the sampling edge, for exactly one cycle; hits (saturating) +1.
- Read port:
  - rd_en=1 at edge N: rd_data and rd_valid=1 are registered at edge N, so they are visible in the cycle after the request. rd_valid drops at edge N+1 unless rd_en is held.
  - Returned value is the statistic before any update at edge N.
  - rd_sel map: 0..3 = cnt0..cnt3; 4 = max_run; 5 = trans; 6 = hits; 7 = 0.
  - rd_data holds its last value when rd_valid=0.
  - Back-to-back rd_en is allowed: one result per cycle.
- clr=1 at an edge:
  - Zeroes all statistics and cur_run, sets prev_valid=0 and FSM=IDLE, forces seq_hit=0.
  - Any same-cycle sample is discarded; clr wins.
  - A same-cycle rd_en returns the pre-clear value.
- No combinational path from any input to any output.

Test Plan:
- Walk with en=1, codes 00,01,11,10 → seq_hit pulses once, one cycle after the 10 sample. Reads: sel0..3 each =1, sel4=1, sel5=3, sel6=1.
- Walk 00,00,01,00,01,11,10 (restart via 00) → exactly one seq_hit. Reads: cnt0=3, cnt1=2, sel5=5, sel4=2.
- 300 consecutive samples of code 11 with CNT_W=8 → cnt3=255, max_run=255, trans=0. No wrap; the read after the 300th sample still returns 255.
- en toggling: samples 00,(en=0 while code=11),01,11,10 → the en=0 cycle is ignored, seq_hit fires, cnt3=1.
- Issue clr in the same cycle as a 10 sample that would complete the walk, with rd_en sel=6 in that cycle → no seq_hit. Read returns the pre-clear hit count, and a following read of sel6 returns 0. The next sample does not increment trans.
- Assert rst asynchronously mid-sequence (FSM in S11) and with rd_en pending → outputs drop to 0 immediately without a clock edge. After release, the codes 10,00,01,11,10 give exactly one hit.
